// File: rtl/apb_reg_slave.sv
// APB register slave: ID, live STATUS and NUM_REGS-2 read/write control words.
// Optional wait-state insertion is compiled in with `define APB_SLV_WAIT_EN.
module apb_reg_slave #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA5B2_0001
) (
    input  logic                                 hclk,
    input  logic                                 hreset_n,
    input  logic                                 psel,
    input  logic                                 penable,
    input  logic [ADDR_WIDTH-1:0]                paddr,
    input  logic                                 pwrite,
    input  logic [DATA_WIDTH-1:0]                pwdata,
    input  logic [DATA_WIDTH-1:0]                status_in,
    output logic [DATA_WIDTH-1:0]                prdata,
    output logic                                 pready,
    output logic                                 pslverr,
    output logic [DATA_WIDTH*(NUM_REGS-2)-1:0]   rw_regs
);

    localparam int IW = ADDR_WIDTH - 2;

`ifdef APB_SLV_WAIT_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RESP = 2'd1, ST_WAIT = 2'd2} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RESP = 2'd1} state_e;
`endif

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdval_q, rdval_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-2];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS-2];
`ifdef APB_SLV_WAIT_EN
    logic [3:0]            cnt_q, cnt_d;
`endif

    logic [IW-1:0]         idx;
    logic                  dec_err;
    logic [DATA_WIDTH-1:0] rd_val;

    assign idx = paddr[ADDR_WIDTH-1:2];

    // Decode of the address presented in the setup phase; writes and errors read back as 0.
    always_comb begin
        dec_err = (paddr[1:0] != 2'b00) || (int'(idx) >= NUM_REGS) ||
                  (pwrite && (int'(idx) < 2));
        rd_val  = '0;
        if (int'(idx) == 0) begin
            rd_val = ID_VALUE;
        end else if (int'(idx) == 1) begin
            rd_val = status_in;
        end else begin
            for (int i = 0; i < NUM_REGS - 2; i++) begin
                if (int'(idx) == i + 2) rd_val = regs_q[i];
            end
        end
        if (dec_err || pwrite) rd_val = '0;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdval_d   = rdval_q;
        regs_d    = regs_q;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
`ifdef APB_SLV_WAIT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    idx_d     = idx;
                    write_d   = pwrite;
                    wdata_d   = pwdata;
                    err_d     = dec_err;
                    rdval_d   = rd_val;
                    state_d   = ST_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = dec_err;
                    prdata_d  = rd_val;
`ifdef APB_SLV_WAIT_EN
                    if (WAIT_CYCLES != 0) begin
                        state_d   = ST_WAIT;
                        cnt_d     = 4'(WAIT_CYCLES);
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end
`endif
                end
            end
`ifdef APB_SLV_WAIT_EN
            ST_WAIT: begin
                if (!psel || !penable) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d   = ST_RESP;
                    cnt_d     = 4'd0;
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                    prdata_d  = rdval_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            ST_RESP: begin
                // Commit only if the master is still in the access phase at the closing edge.
                if (write_q && !err_q && psel && penable) begin
                    for (int i = 0; i < NUM_REGS - 2; i++) begin
                        if (int'(idx_q) == i + 2) regs_d[i] = wdata_q;
                    end
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the control-word array is reset with the rest of the state because
    // software expects every R/W word to read 0 after reset.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rdval_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < NUM_REGS - 2; i++) regs_q[i] <= '0;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            rdval_q   <= rdval_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            regs_q    <= regs_d;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        rw_regs = '0;
        for (int i = 0; i < NUM_REGS - 2; i++) begin
            rw_regs[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave: table-driven APB transfers with a response scoreboard.
// Adapts its expected wait-state count to whether APB_SLV_WAIT_EN is defined.
module tb_apb_reg_slave;

`ifdef APB_SLV_WAIT_EN
    localparam int WAITS = 2;
`else
    localparam int WAITS = 0;
`endif
    localparam int NREG = 8;
    localparam logic [31:0] STATUS_VAL = 32'h1234_5678;

    logic          hclk;
    logic          hreset_n;
    logic          psel;
    logic          penable;
    logic [7:0]    paddr;
    logic          pwrite;
    logic [31:0]   pwdata;
    logic [31:0]   status_in;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;
    logic [191:0]  rw_regs;

    apb_reg_slave #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (32),
        .NUM_REGS    (NREG),
        .WAIT_CYCLES (2),
        .ID_VALUE    (32'hA5B2_0001)
    ) dut (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .psel      (psel),
        .penable   (penable),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .status_in (status_in),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .rw_regs   (rw_regs)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   resp_cyc = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One APB transfer; psel stays high afterwards so a following call is back-to-back.
    task automatic apb_xfer(input logic [7:0] a, input logic w, input logic [31:0] d,
                            input logic [31:0] er, input logic ee);
        exp_t e;
        exp_t got;
        int   n;
        @(negedge hclk);
        check("pready_low_before_setup", 192'(pready), 192'(0));
        check("prdata_zero_outside_resp", 192'(prdata), 192'(0));
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
        e.rdata = er; e.err = ee;
        sb.push_back(e);
        @(negedge hclk);
        penable = 1'b1;
        n = 0;
        while (!pready && n < 40) begin
            @(negedge hclk);
            n++;
        end
        got = sb.pop_front();
        if (!pready) begin
            check("pready_timeout", 192'(0), 192'(1));
        end else begin
            check("wait_states", 192'(n), 192'(WAITS));
            check("prdata", 192'(prdata), 192'(got.rdata));
            check("pslverr", 192'(pslverr), 192'(got.err));
        end
        resp_cyc = cyc;
    endtask

    task automatic bus_idle();
        @(negedge hclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        int last_resp;
        psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0;
        status_in = STATUS_VAL;
        hreset_n = 1'b0;
        #17;
        check("reset_pready", 192'(pready), 192'(0));
        check("reset_pslverr", 192'(pslverr), 192'(0));
        check("reset_prdata", 192'(prdata), 192'(0));
        check("reset_rw_regs", rw_regs, 192'(0));
        hreset_n = 1'b1;

        //           addr   wr    wdata           exp_rdata       err
        vecs.push_back('{8'h08, 1'b1, 32'hDEAD_BEEF, 32'h0,          1'b0});
        vecs.push_back('{8'h08, 1'b0, 32'h0,         32'hDEAD_BEEF,  1'b0});
        vecs.push_back('{8'h00, 1'b0, 32'h0,         32'hA5B2_0001,  1'b0});
        vecs.push_back('{8'h04, 1'b0, 32'h0,         STATUS_VAL,     1'b0});
        vecs.push_back('{8'h04, 1'b1, 32'hFFFF_FFFF, 32'h0,          1'b1});
        vecs.push_back('{8'h04, 1'b0, 32'h0,         STATUS_VAL,     1'b0});
        vecs.push_back('{8'h20, 1'b0, 32'h0,         32'h0,          1'b1});
        vecs.push_back('{8'h09, 1'b0, 32'h0,         32'h0,          1'b1});
        vecs.push_back('{8'h09, 1'b1, 32'h0000_1111, 32'h0,          1'b1});
        vecs.push_back('{8'h00, 1'b1, 32'h0000_0001, 32'h0,          1'b1});
        vecs.push_back('{8'h00, 1'b0, 32'h0,         32'hA5B2_0001,  1'b0});
        vecs.push_back('{8'h1C, 1'b1, 32'hCAFE_F00D, 32'h0,          1'b0});
        vecs.push_back('{8'h1C, 1'b0, 32'h0,         32'hCAFE_F00D,  1'b0});
        vecs.push_back('{8'h0C, 1'b1, 32'h0000_0001, 32'h0,          1'b0});
        vecs.push_back('{8'h10, 1'b1, 32'h0000_0002, 32'h0,          1'b0});
        vecs.push_back('{8'h0C, 1'b0, 32'h0,         32'h0000_0001,  1'b0});
        vecs.push_back('{8'h1D, 1'b1, 32'h0000_0005, 32'h0,          1'b1});
        vecs.push_back('{8'h1C, 1'b0, 32'h0,         32'hCAFE_F00D,  1'b0});
        vecs.push_back('{8'hFC, 1'b0, 32'h0,         32'h0,          1'b1});

        // Whole table runs back-to-back: consecutive responses are WAITS+2 cycles apart.
        last_resp = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            apb_xfer(vecs[i].addr, vecs[i].write, vecs[i].wdata,
                     vecs[i].exp_rdata, vecs[i].exp_err);
            if (i > 0) check("back_to_back_spacing", 192'(resp_cyc - last_resp), 192'(WAITS + 2));
            last_resp = resp_cyc;
        end
        bus_idle();
        check("rw_regs_after_table", rw_regs,
              {32'hCAFE_F00D, 32'h0, 32'h0, 32'h2, 32'h1, 32'hDEAD_BEEF});

`ifdef APB_SLV_WAIT_EN
        // Abort: drop psel after one enable cycle of a write to 0x08.
        begin
            int seen;
            seen = 0;
            @(negedge hclk);
            psel = 1'b1; penable = 1'b0; paddr = 8'h08; pwrite = 1'b1; pwdata = 32'h5555_5555;
            @(negedge hclk);
            penable = 1'b1;
            if (pready) seen++;
            @(negedge hclk);
            if (pready) seen++;
            psel = 1'b0; penable = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge hclk);
                if (pready) seen++;
            end
            check("abort_no_pready", 192'(seen), 192'(0));
            check("abort_no_commit", 192'(rw_regs[31:0]), 192'(32'hDEAD_BEEF));
            apb_xfer(8'h08, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
            bus_idle();
        end
`endif

        // Asynchronous reset in the first enable cycle of a read of ID, then a write.
        apb_xfer(8'h14, 1'b1, 32'h0000_0077, 32'h0, 1'b0);
        bus_idle();
        check("write_visible_word5", 192'(rw_regs[127:96]), 192'(32'h77));
        @(negedge hclk);
        psel = 1'b1; penable = 1'b0; paddr = 8'h00; pwrite = 1'b0;
        @(negedge hclk);
        penable = 1'b1;
        #1 hreset_n = 1'b0;
        #1;
        check("async_reset_pready", 192'(pready), 192'(0));
        check("async_reset_pslverr", 192'(pslverr), 192'(0));
        check("async_reset_prdata", 192'(prdata), 192'(0));
        check("async_reset_rw_regs", rw_regs, 192'(0));
        bus_idle();
        @(negedge hclk);
        hreset_n = 1'b1;
        apb_xfer(8'h08, 1'b0, 32'h0, 32'h0, 1'b0);
        apb_xfer(8'h18, 1'b1, 32'h0BAD_F00D, 32'h0, 1'b0);
        apb_xfer(8'h18, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0);
        bus_idle();
        check("rw_regs_word6", 192'(rw_regs[159:128]), 192'(32'h0BAD_F00D));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
